// File: rtl/id_hazard_unit.sv
// Decode-stage operand resolution with EX/MEM forwarding, a per-register
// pending-load scoreboard that raises load-use stalls, and a stall-cycle counter.
module id_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic                  id_reg1_read_i,
    input  logic                  id_reg2_read_i,
    input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
    input  logic [DATA_W-1:0]     id_imm_i,
    input  logic                  id_wreg_i,
    input  logic [REG_ADDR_W-1:0] id_wd_i,
    input  logic                  id_is_load_i,
    input  logic [DATA_W-1:0]     reg1_data_i,
    input  logic [DATA_W-1:0]     reg2_data_i,
    input  logic                  ex_wreg_i,
    input  logic [REG_ADDR_W-1:0] ex_wd_i,
    input  logic [DATA_W-1:0]     ex_wdata_i,
    input  logic                  mem_wreg_i,
    input  logic [REG_ADDR_W-1:0] mem_wd_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  clr_cnt_i,
    output logic [DATA_W-1:0]     reg1_o,
    output logic [DATA_W-1:0]     reg2_o,
    output logic                  stall_req_o,
    output logic                  issue_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int         NUM_REGS   = 2 ** REG_ADDR_W;
    localparam logic [2:0] LOAD_LAT_V = 3'(LOAD_LAT);

    logic [2:0]       r_pend      [NUM_REGS];
    logic [2:0]       w_pend_next [NUM_REGS];
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_stall_req;
    logic             w_issue;

    // One identical resolver per source operand; gi selects which port pair it serves.
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
        logic                  w_rd;
        logic [REG_ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0]     w_rdata;
        logic [DATA_W-1:0]     w_op;
        logic                  w_haz;

        assign w_rd    = (gi == 0) ? id_reg1_read_i : id_reg2_read_i;
        assign w_addr  = (gi == 0) ? id_reg1_addr_i : id_reg2_addr_i;
        assign w_rdata = (gi == 0) ? reg1_data_i    : reg2_data_i;

        always_comb begin
            w_op = w_rdata;
            if (!w_rd)
                w_op = id_imm_i;
            else if (w_addr == '0)
                w_op = '0;
            else if (ex_wreg_i && (ex_wd_i == w_addr))
                w_op = ex_wdata_i;
            else if (mem_wreg_i && (mem_wd_i == w_addr))
                w_op = mem_wdata_i;
        end

        assign w_haz = w_rd && (w_addr != '0) && (r_pend[w_addr] != 3'd0);
    end

    assign w_stall_req = id_valid_i && !flush_i && (g_opnd[0].w_haz || g_opnd[1].w_haz);
    assign w_issue     = id_valid_i && !w_stall_req && !stall_i && !flush_i;

    // An issuing writer re-arms (load) or clears (non-load) its entry instead of decrementing.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
        if (gi == 0) begin : g_r0
            assign w_pend_next[gi] = 3'd0;
        end else begin : g_rn
            logic w_claim;
            assign w_claim = w_issue && id_wreg_i && (id_wd_i == REG_ADDR_W'(gi));
            assign w_pend_next[gi] = w_claim ? (id_is_load_i ? LOAD_LAT_V : 3'd0)
                                   : (r_pend[gi] != 3'd0) ? r_pend[gi] - 3'd1
                                   : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                r_pend[r] <= 3'd0;
        end else if (!stall_i) begin
            r_pend <= w_pend_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (clr_cnt_i)
            r_stall_cnt <= '0;
        else if (w_stall_req && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign reg1_o      = rst ? g_opnd[0].w_op : '0;
    assign reg2_o      = rst ? g_opnd[1].w_op : '0;
    assign stall_req_o = rst && w_stall_req;
    assign issue_o     = rst && w_issue;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_unit.sv
// Bench for id_hazard_unit: two instances (LOAD_LAT=1/CNT_W=16 and LOAD_LAT=3/CNT_W=3)
// share one stimulus stream and are compared every cycle against a wait-count model.
module tb_id_hazard_unit;

    logic        clk;
    logic        rst;
    logic        valid, rd1, rd2, wreg, isload;
    logic [4:0]  a1, a2, wd, ex_wd, mem_wd;
    logic [31:0] imm, rdat1, rdat2, ex_wdata, mem_wdata;
    logic        ex_wreg, mem_wreg, stall, flush, clr;

    logic [31:0] a_reg1, a_reg2, b_reg1, b_reg2;
    logic        a_stall, a_issue, b_stall, b_issue;
    logic [15:0] a_cnt;
    logic [2:0]  b_cnt;

    int nvec = 0;
    int nmis = 0;

    // Model state: remaining wait cycles per register and counter value, per instance.
    int pend_m [2][32];
    int cnt_m  [2];
    int lat_m  [2] = '{1, 3};
    int cmax_m [2] = '{65535, 7};

    id_hazard_unit #(.REG_ADDR_W(5), .DATA_W(32), .LOAD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid_i(valid),
        .id_reg1_read_i(rd1), .id_reg2_read_i(rd2),
        .id_reg1_addr_i(a1), .id_reg2_addr_i(a2), .id_imm_i(imm),
        .id_wreg_i(wreg), .id_wd_i(wd), .id_is_load_i(isload),
        .reg1_data_i(rdat1), .reg2_data_i(rdat2),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .stall_i(stall), .flush_i(flush), .clr_cnt_i(clr),
        .reg1_o(a_reg1), .reg2_o(a_reg2), .stall_req_o(a_stall),
        .issue_o(a_issue), .stall_cnt_o(a_cnt)
    );

    id_hazard_unit #(.REG_ADDR_W(5), .DATA_W(32), .LOAD_LAT(3), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .id_valid_i(valid),
        .id_reg1_read_i(rd1), .id_reg2_read_i(rd2),
        .id_reg1_addr_i(a1), .id_reg2_addr_i(a2), .id_imm_i(imm),
        .id_wreg_i(wreg), .id_wd_i(wd), .id_is_load_i(isload),
        .reg1_data_i(rdat1), .reg2_data_i(rdat2),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .stall_i(stall), .flush_i(flush), .clr_cnt_i(clr),
        .reg1_o(b_reg1), .reg2_o(b_reg2), .stall_req_o(b_stall),
        .issue_o(b_issue), .stall_cnt_o(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] m_op(input logic rd, input logic [4:0] addr,
                                         input logic [31:0] rdata);
        if (!rd)                             return imm;
        if (addr == 0)                       return 32'd0;
        if (ex_wreg && ex_wd == addr)        return ex_wdata;
        if (mem_wreg && mem_wd == addr)      return mem_wdata;
        return rdata;
    endfunction

    function automatic bit m_stall(input int k);
        bit h1, h2;
        h1 = rd1 && a1 != 0 && pend_m[k][a1] > 0;
        h2 = rd2 && a2 != 0 && pend_m[k][a2] > 0;
        return valid && !flush && (h1 || h2);
    endfunction

    function automatic bit m_issue(input int k);
        return valid && !m_stall(k) && !stall && !flush;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 2; k++) begin
            cnt_m[k] = 0;
            for (int r = 0; r < 32; r++) pend_m[k][r] = 0;
        end
    endtask

    // Per-cycle comparison of both instances against the model, at the falling edge.
    task automatic sample();
        logic [31:0] e1, e2;
        @(negedge clk);
        if (!rst) m_clear();
        e1 = rst ? m_op(rd1, a1, rdat1) : 32'd0;
        e2 = rst ? m_op(rd2, a2, rdat2) : 32'd0;
        chk("a_reg1", a_reg1, e1);
        chk("a_reg2", a_reg2, e2);
        chk("b_reg1", b_reg1, e1);
        chk("b_reg2", b_reg2, e2);
        chk("a_stall", 32'(a_stall), rst ? 32'(m_stall(0)) : 0);
        chk("b_stall", 32'(b_stall), rst ? 32'(m_stall(1)) : 0);
        chk("a_issue", 32'(a_issue), rst ? 32'(m_issue(0)) : 0);
        chk("b_issue", 32'(b_issue), rst ? 32'(m_issue(1)) : 0);
        chk("a_cnt", 32'(a_cnt), 32'(cnt_m[0]));
        chk("b_cnt", 32'(b_cnt), 32'(cnt_m[1]));
    endtask

    task automatic advance();
        bit st, is;
        @(posedge clk);
        if (!rst) begin
            m_clear();
        end else begin
            for (int k = 0; k < 2; k++) begin
                st = m_stall(k);
                is = m_issue(k);
                if (!stall) begin
                    for (int r = 1; r < 32; r++)
                        if (pend_m[k][r] > 0) pend_m[k][r]--;
                    if (is && wreg && wd != 0)
                        pend_m[k][wd] = isload ? lat_m[k] : 0;
                end
                if (clr)                          cnt_m[k] = 0;
                else if (st && cnt_m[k] < cmax_m[k]) cnt_m[k]++;
            end
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic idle();
        valid = 0; rd1 = 0; rd2 = 0; a1 = 0; a2 = 0; wreg = 0; wd = 0; isload = 0;
        ex_wreg = 0; ex_wd = 0; mem_wreg = 0; mem_wd = 0; stall = 0; flush = 0; clr = 0;
    endtask

    task automatic instr(input logic r1, input logic [4:0] ad1, input logic r2,
                         input logic [4:0] ad2, input logic w, input logic [4:0] d,
                         input logic ld);
        valid = 1; rd1 = r1; a1 = ad1; rd2 = r2; a2 = ad2; wreg = w; wd = d; isload = ld;
    endtask

    initial begin
        int pat [6] = '{0, 1, 1, 0, 0, 0};
        int nst;
        m_clear();

        // Reset with every input active
        rst = 0;
        instr(1, 5, 1, 6, 1, 5, 1);
        imm = 32'h0000_1234; rdat1 = 32'h1111_0001; rdat2 = 32'h2222_0002;
        ex_wreg = 1; ex_wd = 5; ex_wdata = 32'hAAAA_5555;
        mem_wreg = 1; mem_wd = 6; mem_wdata = 32'h5555_AAAA;
        stall = 0; flush = 0; clr = 0;
        sample();
        chk("rst_reg1", a_reg1, 32'd0);
        chk("rst_stall", 32'(a_stall), 32'd0);
        chk("rst_issue", 32'(a_issue), 32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        advance();
        cycle();
        rst = 1;
        idle();
        cycle();

        // Load r5, then add r6,r5,r5
        instr(0, 0, 0, 0, 1, 5, 1);
        sample(); chk("ld_issue", 32'(a_issue), 32'd1); advance();
        instr(1, 5, 1, 5, 1, 6, 0);
        sample(); chk("lu_stall", 32'(a_stall), 32'd1); chk("lu_noissue", 32'(a_issue), 32'd0); advance();
        mem_wreg = 1; mem_wd = 5; mem_wdata = 32'hDEAD_BEEF;
        sample();
        chk("lu_reg1", a_reg1, 32'hDEAD_BEEF);
        chk("lu_reg2", a_reg2, 32'hDEAD_BEEF);
        chk("lu_issue", 32'(a_issue), 32'd1);
        chk("lu_b_stall", 32'(b_stall), 32'd1);
        advance();
        idle();
        repeat (3) cycle();

        // Forwarding priority and r0
        instr(1, 3, 0, 0, 0, 0, 0);
        imm = 32'h1234_5678;
        ex_wreg = 1; ex_wd = 3; ex_wdata = 32'h11;
        mem_wreg = 1; mem_wd = 3; mem_wdata = 32'h22;
        sample(); chk("fwd_ex", a_reg1, 32'h11); chk("fwd_imm", a_reg2, 32'h1234_5678); advance();
        ex_wreg = 0;
        sample(); chk("fwd_mem", a_reg1, 32'h22); advance();
        a1 = 0; ex_wreg = 1; ex_wd = 0; ex_wdata = 32'hFF;
        sample(); chk("fwd_r0", a_reg1, 32'd0); advance();
        a1 = 4; rd2 = 1; a2 = 4; ex_wreg = 0; mem_wreg = 0;
        rdat1 = 32'hCAFE_0004; rdat2 = 32'hBEEF_0004;
        sample(); chk("rf_reg1", a_reg1, 32'hCAFE_0004); chk("rf_reg2", a_reg2, 32'hBEEF_0004); advance();

        // LOAD_LAT=3 with two downstream-stall cycles during the hazard
        idle(); clr = 1; cycle(); clr = 0;
        instr(0, 0, 0, 0, 1, 9, 1); cycle();
        instr(1, 9, 0, 0, 0, 0, 0);
        nst = 0;
        for (int i = 0; i < 6; i++) begin
            stall = pat[i][0];
            sample();
            if (b_stall) nst++;
            if (i == 5) chk("lat3_issue", 32'(b_issue), 32'd1);
            advance();
        end
        chk("lat3_stall_cycles", 32'(nst), 32'd5);
        idle();
        sample(); chk("lat3_cnt", 32'(b_cnt), 32'd5); advance();

        // Flush behind a load
        instr(0, 0, 0, 0, 1, 7, 1); cycle();
        instr(1, 7, 0, 0, 0, 0, 0); flush = 1;
        sample();
        chk("fl_a_stall", 32'(a_stall), 32'd0); chk("fl_a_issue", 32'(a_issue), 32'd0);
        chk("fl_b_stall", 32'(b_stall), 32'd0); chk("fl_b_issue", 32'(b_issue), 32'd0);
        advance();
        flush = 0;
        sample(); chk("fl_a_after", 32'(a_issue), 32'd1); chk("fl_b_after", 32'(b_stall), 32'd1); advance();
        idle(); repeat (3) cycle();

        // Counter saturation (3-bit instance) and clear winning over increment
        clr = 1; cycle(); clr = 0;
        instr(0, 0, 0, 0, 1, 10, 1); cycle();
        instr(1, 10, 0, 0, 0, 0, 0); stall = 1;
        repeat (9) cycle();
        sample(); chk("sat_cnt", 32'(b_cnt), 32'd7); chk("sat_stall", 32'(b_stall), 32'd1); advance();
        clr = 1;
        sample(); chk("clr_stall", 32'(b_stall), 32'd1); advance();
        clr = 0;
        sample(); chk("clr_cnt", 32'(b_cnt), 32'd0); advance();
        idle(); repeat (4) cycle();

        // Reset mid-operation drops the pending load
        instr(0, 0, 0, 0, 1, 11, 1); cycle();
        instr(1, 11, 0, 0, 0, 0, 0); rst = 0;
        cycle();
        rst = 1;
        sample();
        chk("rrel_a_stall", 32'(a_stall), 32'd0); chk("rrel_b_stall", 32'(b_stall), 32'd0);
        chk("rrel_issue", 32'(a_issue), 32'd1);
        advance();
        idle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
